rs_lsq: RTL and testbench

- Parametrised in-order load/store reservation queue holding DEPTH entries.
- Generalises the single-entry load/store station. It sits between the dispatch allocator and the load/store unit.
- Each entry captures an operation, its immediate, its operands (as tag or data) and its destination.
- Every entry snoops NCDB result-broadcast channels each cycle. The head entry is issued to the load/store unit, in program order, once both of its operands are ready.

---
 rtl/rs_lsq.sv | 186 ++++++++++++++++++
 tb/tb_rs_lsq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_lsq.sv
// In-order load/store reservation queue. It holds up to DEPTH dispatched
// memory operations in a circular buffer. Every unresolved source operand
// snoops the NCDB result-broadcast channels on every cycle. Only the oldest
// entry may issue, and only once both of its operands hold data. This keeps
// memory operations in program order.
module rs_lsq #(
    parameter int DEPTH = 4,
    parameter int NCDB  = 3,
    parameter int TAGW  = 4,
    parameter int DATAW = 32,
    parameter int OPW   = 6,
    parameter int REGW  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,

    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [OPW-1:0]           alloc_op,
    input  logic [DATAW-1:0]         alloc_imm,
    input  logic [TAGW-1:0]          alloc_tagx,
    input  logic [TAGW-1:0]          alloc_tagy,
    input  logic [DATAW-1:0]         alloc_datax,
    input  logic [DATAW-1:0]         alloc_datay,
    input  logic [TAGW-1:0]          alloc_tagw,
    input  logic [REGW-1:0]          alloc_addrw,

    input  logic [NCDB-1:0]          cdb_valid,
    input  logic [NCDB*TAGW-1:0]     cdb_tag,
    input  logic [NCDB*DATAW-1:0]    cdb_data,

    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [OPW-1:0]           issue_op,
    output logic [DATAW-1:0]         issue_offset,
    output logic [DATAW-1:0]         issue_datax,
    output logic [DATAW-1:0]         issue_datay,
    output logic [TAGW-1:0]          issue_tagw,
    output logic [REGW-1:0]          issue_target,

    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);
    localparam logic [TAGW-1:0] UNLOCKED   = '0;

    // Result of matching one operand tag against the broadcast channels.
    typedef struct packed {
        logic             hit;
        logic [DATAW-1:0] data;
    } snoop_t;

    // Returns the lowest-indexed valid channel that carries the given tag.
    // An unlocked operand (tag 0) never matches.
    function automatic snoop_t snoop(
        input logic [TAGW-1:0]        tag,
        input logic [NCDB-1:0]        valid,
        input logic [NCDB*TAGW-1:0]   tags,
        input logic [NCDB*DATAW-1:0]  data
    );
        snoop_t res;
        res = '0;
        // The scan runs from the highest index down, so the lowest matching index is written last and wins.
        for (int i = NCDB - 1; i >= 0; i--) begin
            if (tag != UNLOCKED && valid[i] && tags[i*TAGW +: TAGW] == tag) begin
                res.hit  = 1'b1;
                res.data = data[i*DATAW +: DATAW];
            end
        end
        return res;
    endfunction

    // Entry storage. An entry is live when it lies between head and head+count.
    logic [OPW-1:0]   op_q    [DEPTH];
    logic [DATAW-1:0] imm_q   [DEPTH];
    logic [TAGW-1:0]  tagx_q  [DEPTH];
    logic [DATAW-1:0] datax_q [DEPTH];
    logic [TAGW-1:0]  tagy_q  [DEPTH];
    logic [DATAW-1:0] datay_q [DEPTH];
    logic [TAGW-1:0]  tagw_q  [DEPTH];
    logic [REGW-1:0]  addrw_q [DEPTH];

    logic [PTRW-1:0]  head_q;
    logic [PTRW-1:0]  tail_q;
    logic [CNTW-1:0]  count_q;

    snoop_t           snx [DEPTH];
    snoop_t           sny [DEPTH];
    snoop_t           snx_in;
    snoop_t           sny_in;

    logic             alloc_fire;
    logic             issue_fire;

    // Handshakes and head presentation come from registers only.
    assign alloc_ready  = (count_q != FULL_COUNT);
    assign issue_valid  = (count_q != '0)
                          && (tagx_q[head_q] == UNLOCKED)
                          && (tagy_q[head_q] == UNLOCKED);
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign issue_fire   = issue_valid && issue_ready;

    assign issue_op     = op_q[head_q];
    assign issue_offset = imm_q[head_q];
    assign issue_datax  = datax_q[head_q];
    assign issue_datay  = datay_q[head_q];
    assign issue_tagw   = tagw_q[head_q];
    assign issue_target = addrw_q[head_q];
    assign count        = count_q;

    // Snoop results for every stored operand and for the incoming operands.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            snx[e] = snoop(tagx_q[e], cdb_valid, cdb_tag, cdb_data);
            sny[e] = snoop(tagy_q[e], cdb_valid, cdb_tag, cdb_data);
        end
        snx_in = snoop(alloc_tagx, cdb_valid, cdb_tag, cdb_data);
        sny_in = snoop(alloc_tagy, cdb_valid, cdb_tag, cdb_data);
    end

    // Head/tail pointers and occupancy. Both pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: every register here is written with <=, so all of them update together from the values before the edge.
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) tail_q <= tail_q + PTRW'(1);
            if (issue_fire) head_q <= head_q + PTRW'(1);
            case ({alloc_fire, issue_fire})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry contents: wake up operands on a broadcast and write new entries at the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entry array is reset, not just the pointers, so the head fields read as zero after reset.
            for (int e = 0; e < DEPTH; e++) begin
                op_q[e]    <= '0;
                imm_q[e]   <= '0;
                tagx_q[e]  <= '0;
                datax_q[e] <= '0;
                tagy_q[e]  <= '0;
                datay_q[e] <= '0;
                tagw_q[e]  <= '0;
                addrw_q[e] <= '0;
            end
        end else if (flush) begin
            for (int e = 0; e < DEPTH; e++) begin
                tagx_q[e] <= UNLOCKED;
                tagy_q[e] <= UNLOCKED;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (snx[e].hit) begin
                    tagx_q[e]  <= UNLOCKED;
                    datax_q[e] <= snx[e].data;
                end
                if (sny[e].hit) begin
                    tagy_q[e]  <= UNLOCKED;
                    datay_q[e] <= sny[e].data;
                end
            end
            // The tail slot is free, so writing it after the snoop loop never overwrites a live entry.
            if (alloc_fire) begin
                op_q[tail_q]    <= alloc_op;
                imm_q[tail_q]   <= alloc_imm;
                tagw_q[tail_q]  <= alloc_tagw;
                addrw_q[tail_q] <= alloc_addrw;
                tagx_q[tail_q]  <= snx_in.hit ? UNLOCKED    : alloc_tagx;
                datax_q[tail_q] <= snx_in.hit ? snx_in.data : alloc_datax;
                tagy_q[tail_q]  <= sny_in.hit ? UNLOCKED    : alloc_tagy;
                datay_q[tail_q] <= sny_in.hit ? sny_in.data : alloc_datay;
            end
        end
    end

endmodule

// File: tb/tb_rs_lsq.sv
// Self-checking bench for rs_lsq. A queue-based reference model predicts
// which instruction issues on each cycle and pushes it onto a scoreboard.
// A separate monitor pops and compares on every issue handshake.
module tb_rs_lsq;

    localparam int DEPTH = 4;
    localparam int NCDB  = 3;
    localparam int TAGW  = 4;
    localparam int DATAW = 32;
    localparam int OPW   = 6;
    localparam int REGW  = 5;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    rst, flush;
    logic                    alloc_valid, alloc_ready;
    logic [OPW-1:0]          alloc_op;
    logic [DATAW-1:0]        alloc_imm, alloc_datax, alloc_datay;
    logic [TAGW-1:0]         alloc_tagx, alloc_tagy, alloc_tagw;
    logic [REGW-1:0]         alloc_addrw;
    logic [NCDB-1:0]         cdb_valid;
    logic [NCDB*TAGW-1:0]    cdb_tag;
    logic [NCDB*DATAW-1:0]   cdb_data;
    logic                    issue_valid, issue_ready;
    logic [OPW-1:0]          issue_op;
    logic [DATAW-1:0]        issue_offset, issue_datax, issue_datay;
    logic [TAGW-1:0]         issue_tagw;
    logic [REGW-1:0]         issue_target;
    logic [CNTW-1:0]         count;

    always #5 clk = ~clk;

    rs_lsq #(
        .DEPTH(DEPTH), .NCDB(NCDB), .TAGW(TAGW),
        .DATAW(DATAW), .OPW(OPW), .REGW(REGW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_op(alloc_op), .alloc_imm(alloc_imm),
        .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
        .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
        .alloc_tagw(alloc_tagw), .alloc_addrw(alloc_addrw),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_offset(issue_offset),
        .issue_datax(issue_datax), .issue_datay(issue_datay),
        .issue_tagw(issue_tagw), .issue_target(issue_target),
        .count(count)
    );

    typedef struct {
        logic [OPW-1:0]   op;
        logic [DATAW-1:0] imm;
        logic [TAGW-1:0]  tx;
        logic [DATAW-1:0] dx;
        logic [TAGW-1:0]  ty;
        logic [DATAW-1:0] dy;
        logic [TAGW-1:0]  tw;
        logic [REGW-1:0]  aw;
    } ent_t;

    ent_t mq[$];     // reference model: live entries, oldest first
    ent_t exp_q[$];  // scoreboard: expected issues in order

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Resolves an operand against the current broadcast, with the lowest channel winning.
    function automatic void resolve(inout logic [TAGW-1:0] t, inout logic [DATAW-1:0] d);
        bit found;
        found = 0;
        if (t != '0) begin
            for (int i = 0; i < NCDB; i++) begin
                if (!found && cdb_valid[i] && cdb_tag[i*TAGW +: TAGW] == t) begin
                    found = 1;
                    d = cdb_data[i*DATAW +: DATAW];
                end
            end
            if (found) t = '0;
        end
    endfunction

    function automatic bit model_head_ready();
        return mq.size() > 0 && mq[0].tx == '0 && mq[0].ty == '0;
    endfunction

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit   can_alloc;
        bit   do_issue;
        ent_t e;
        if (rst || flush) begin
            mq.delete();
            return;
        end
        can_alloc = mq.size() < DEPTH;
        do_issue  = model_head_ready() && issue_ready;
        if (do_issue) begin
            exp_q.push_back(mq[0]);
            void'(mq.pop_front());
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            resolve(e.tx, e.dx);
            resolve(e.ty, e.dy);
            mq[i] = e;
        end
        if (alloc_valid && can_alloc) begin
            e.op = alloc_op;    e.imm = alloc_imm;
            e.tx = alloc_tagx;  e.dx  = alloc_datax;
            e.ty = alloc_tagy;  e.dy  = alloc_datay;
            e.tw = alloc_tagw;  e.aw  = alloc_addrw;
            resolve(e.tx, e.dx);
            resolve(e.ty, e.dy);
            mq.push_back(e);
        end
    endtask

    task automatic check_status();
        check("count",       64'(count),       64'(mq.size()));
        check("alloc_ready", 64'(alloc_ready), 64'(mq.size() < DEPTH));
        check("issue_valid", 64'(issue_valid), 64'(model_head_ready()));
    endtask

    // One cycle: predict with the applied inputs, pass the edge, then compare the status outputs.
    task automatic tick();
        model_step();
        @(negedge clk);
        check_status();
    endtask

    task automatic idle();
        rst = 0; flush = 0; alloc_valid = 0; issue_ready = 0;
        alloc_op = '0; alloc_imm = '0; alloc_tagx = '0; alloc_tagy = '0;
        alloc_datax = '0; alloc_datay = '0; alloc_tagw = '0; alloc_addrw = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic set_alloc(input logic [OPW-1:0] op, input logic [DATAW-1:0] imm,
                             input logic [TAGW-1:0] tx, input logic [DATAW-1:0] dx,
                             input logic [TAGW-1:0] ty, input logic [DATAW-1:0] dy,
                             input logic [TAGW-1:0] tw, input logic [REGW-1:0] aw);
        alloc_valid = 1;
        alloc_op = op;   alloc_imm = imm;
        alloc_tagx = tx; alloc_datax = dx;
        alloc_tagy = ty; alloc_datay = dy;
        alloc_tagw = tw; alloc_addrw = aw;
    endtask

    task automatic set_cdb(input int ch, input logic [TAGW-1:0] t, input logic [DATAW-1:0] d);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TAGW +: TAGW] = t;
        cdb_data[ch*DATAW +: DATAW] = d;
    endtask

    function automatic logic [TAGW-1:0] rand_src_tag();
        if ($urandom_range(0, 2) == 0) return TAGW'($urandom_range(1, 7));
        return '0;
    endfunction

    // Monitor: on each observed issue handshake, pop the expected entry and compare.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !flush && issue_valid === 1'b1 && issue_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL issue_unexpected: got a handshake with op 0x%0h, expected none at %0t",
                             issue_op, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_op",     64'(issue_op),     64'(e.op));
                    check("issue_offset", 64'(issue_offset), 64'(e.imm));
                    check("issue_datax",  64'(issue_datax),  64'(e.dx));
                    check("issue_datay",  64'(issue_datay),  64'(e.dy));
                    check("issue_tagw",   64'(issue_tagw),   64'(e.tw));
                    check("issue_target", 64'(issue_target), 64'(e.aw));
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        check("rst_issue_op",     64'(issue_op),     64'd0);
        check("rst_issue_offset", 64'(issue_offset), 64'd0);
        check("rst_issue_datax",  64'(issue_datax),  64'd0);
        check("rst_issue_target", 64'(issue_target), 64'd0);

        // Single ready instruction: visible one cycle after allocation, then drained.
        idle();
        set_alloc(6'd3, 32'd8, 4'd0, 32'h100, 4'd0, 32'h55, 4'd1, 5'd2);
        tick();
        check("first_count", 64'(count), 64'd1);
        idle();
        issue_ready = 1;
        tick();
        check("first_drained", 64'(count), 64'd0);

        // Fill with tagx=5, one wake-up on channel 2, then drain so the pointers wrap.
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(6'(10 + i), 32'(i * 4), 4'd5, 32'd0, 4'd0, 32'(i), 4'(i + 1), 5'(i));
            tick();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_alloc_ready", 64'(alloc_ready), 64'd0);
        idle();
        set_cdb(2, 4'd5, 32'hABC);
        tick();
        idle();
        issue_ready = 1;
        for (int i = 0; i < DEPTH; i++) tick();

        // Unready head blocks a ready younger entry until tag 7 is broadcast.
        idle();
        set_alloc(6'd20, 32'd1, 4'd7, 32'd0, 4'd0, 32'h11, 4'd3, 5'd3);
        tick();
        set_alloc(6'd21, 32'd2, 4'd0, 32'h22, 4'd0, 32'h33, 4'd4, 5'd4);
        tick();
        idle();
        issue_ready = 1;
        for (int i = 0; i < 3; i++) tick();
        set_cdb(1, 4'd7, 32'h777);
        tick();
        idle();
        issue_ready = 1;
        for (int i = 0; i < 3; i++) tick();

        // Snoop on allocate with two matching channels; channel 0 must win.
        idle();
        set_alloc(6'd30, 32'd5, 4'd0, 32'h44, 4'd9, 32'd0, 4'd6, 5'd6);
        set_cdb(0, 4'd9, 32'h1234);
        set_cdb(1, 4'd9, 32'hDEAD);
        tick();
        check("alloc_snoop_datay", 64'(issue_datay), 64'h1234);
        idle();
        issue_ready = 1;
        tick();

        // Full and issuing while dispatch presents: no allocation this cycle, then it succeeds.
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(6'(40 + i), 32'(i), 4'd0, 32'(i), 4'd0, 32'(i), 4'd2, 5'(i));
            tick();
        end
        set_alloc(6'd50, 32'd9, 4'd0, 32'h99, 4'd0, 32'h98, 4'd5, 5'd9);
        issue_ready = 1;
        tick();
        check("full_issue_count", 64'(count), 64'd3);
        issue_ready = 0;
        tick();
        check("retry_alloc_count", 64'(count), 64'd4);
        idle();
        issue_ready = 1;
        for (int i = 0; i < DEPTH; i++) tick();

        // Flush with three waiting entries and a new instruction offered.
        idle();
        for (int i = 0; i < 3; i++) begin
            set_alloc(6'(60 + i), 32'(i), 4'd3, 32'd0, 4'd0, 32'd0, 4'd1, 5'(i));
            tick();
        end
        set_alloc(6'd63, 32'd7, 4'd0, 32'd1, 4'd0, 32'd2, 4'd1, 5'd1);
        issue_ready = 1;
        flush = 1;
        tick();
        check("flush_count", 64'(count), 64'd0);
        check("flush_issue_valid", 64'(issue_valid), 64'd0);

        // Randomised traffic including occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 1) == 1)
                set_alloc(6'($urandom), $urandom, rand_src_tag(), $urandom,
                          rand_src_tag(), $urandom, 4'($urandom), 5'($urandom));
            issue_ready = ($urandom_range(0, 3) != 0);
            for (int ch = 0; ch < NCDB; ch++)
                if ($urandom_range(0, 1) == 1)
                    set_cdb(ch, 4'($urandom_range(1, 7)), $urandom);
            tick();
        end

        // Drain: broadcast every tag in turn until the queue empties.
        for (int c = 0; c < 24; c++) begin
            idle();
            issue_ready = 1;
            for (int ch = 0; ch < NCDB; ch++)
                set_cdb(ch, 4'(((c * NCDB + ch) % 7) + 1), 32'(c * 16 + ch));
            tick();
        end
        idle();
        tick();
        #3;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("final_count", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
